// File: rtl/tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// tick_gen_pkg
// Shared types and constants for the multi-channel tick generator.
//   ch_state_e     : per-channel sequencing state
//   DIV_1HZ_100MHZ : divisor giving a 1 s tick from a 100 MHz board clock
//   DIV_25MHZ      : divisor giving a 25 MHz tick (pixel clock) from 100 MHz
//   sel_width()    : width of a channel-select field, never less than 1 bit
// -----------------------------------------------------------------------------
package tick_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } ch_state_e;

  localparam int unsigned DIV_1HZ_100MHZ = 32'd100000000;
  localparam int unsigned DIV_25MHZ      = 32'd4;

  function automatic int sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/tick_generator_multi_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
// One timebase channel: divisor register, up-counter with >= terminal compare,
// run/pause/one-shot sequencing, single-cycle tick, 50% square wave and a
// saturating tick count.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   en_i         run enable; low pauses the counter
//   clear_i      synchronous clear of counter, count, square wave and done
//   oneshot_i    1 = stop in DONE after the first tick
//   load_i       load strobe for the divisor register
//   load_data_i  divisor value taken on load_i
//   tick_o       one-cycle pulse per period
//   sq_clk_o     toggles on every tick
//   done_o       one-shot has fired
//   elapsed_o    saturating tick count
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | cleared, waiting for en_i; counter at 0
// RUN    | counting enabled edges toward div_eff
// PAUSED | en_i dropped while running; counter and sq_clk held
// DONE   | one-shot fired; counter 0, ignores en_i until clear/reset
// -----------------------------------------------------------------------------
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int          CNT_W       = 28,
  parameter int unsigned DEFAULT_DIV = DIV_1HZ_100MHZ,
  parameter int          ELAPSED_W   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic                 oneshot_i,
  input  logic                 load_i,
  input  logic [CNT_W-1:0]     load_data_i,
  output logic                 tick_o,
  output logic                 sq_clk_o,
  output logic                 done_o,
  output logic [ELAPSED_W-1:0] elapsed_o
);

  ch_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     div_q, div_d;
  logic [CNT_W-1:0]     div_eff;
  logic                 tick_q, tick_d;
  logic                 sq_q, sq_d;
  logic                 done_q, done_d;
  logic [ELAPSED_W-1:0] el_q, el_d;
  logic                 terminal;

  // A zero divisor would never terminate; run it as divide-by-one.
  assign div_eff = (div_q == '0) ? CNT_W'(1) : div_q;

  // >= rather than == so that shrinking the divisor below the current count
  // wraps on the next enabled edge instead of running through 2^CNT_W.
  assign terminal = (cnt_q >= (div_eff - CNT_W'(1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    sq_d    = sq_q;
    el_d    = el_q;
    // The divisor load is independent of clear and of the FSM; the compare
    // above still uses the old divisor during a load cycle.
    div_d   = load_i ? load_data_i : div_q;

    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      sq_d    = 1'b0;
      el_d    = '0;
    end else begin
      unique case (state_q)
        IDLE, RUN, PAUSED: begin
          if (en_i) begin
            // The enabling edge itself counts, so from IDLE the first tick
            // lands on the div_eff-th enabled edge.
            state_d = RUN;
            if (terminal) begin
              cnt_d  = '0;
              tick_d = 1'b1;
              sq_d   = ~sq_q;
              if (el_q != '1) el_d = el_q + ELAPSED_W'(1);
              if (oneshot_i) state_d = DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (state_q == RUN) begin
            state_d = PAUSED;
          end
        end
        DONE: begin
          cnt_d = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= CNT_W'(DEFAULT_DIV);
      tick_q  <= 1'b0;
      sq_q    <= 1'b0;
      done_q  <= 1'b0;
      el_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      sq_q    <= sq_d;
      done_q  <= done_d;
      el_q    <= el_d;
    end
  end

  assign tick_o    = tick_q;
  assign sq_clk_o  = sq_q;
  assign done_o    = done_q;
  assign elapsed_o = el_q;

endmodule

// File: rtl/tick_generator_multi.sv
// -----------------------------------------------------------------------------
// tick_generator_multi
// Multi-channel programmable timebase. Each channel divides clk into a
// one-cycle tick, a 50% square wave and a saturating tick count, with
// pause/resume, clear and one-shot control. Divisors are written one channel
// at a time through div_wr/div_sel/div_data.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   ch_en       per-channel run enable
//   ch_clear    per-channel synchronous clear
//   ch_oneshot  per-channel one-shot mode
//   div_wr      divisor write strobe
//   div_sel     channel addressed by div_wr (out-of-range writes are dropped)
//   div_data    new divisor value
//   tick        per-channel one-cycle tick
//   sq_clk      per-channel square wave, period 2*div
//   done        per-channel one-shot fired flag
//   elapsed     per-channel tick count, channel i at [i*ELAPSED_W +: ELAPSED_W]
// -----------------------------------------------------------------------------
module tick_generator_multi
  import tick_gen_pkg::*;
#(
  parameter  int          NUM_CH      = 2,
  parameter  int          CNT_W       = 28,
  parameter  int unsigned DEFAULT_DIV = DIV_1HZ_100MHZ,
  parameter  int          ELAPSED_W   = 8,
  localparam int          SEL_W       = sel_width(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic [NUM_CH-1:0]           ch_clear,
  input  logic [NUM_CH-1:0]           ch_oneshot,
  input  logic                        div_wr,
  input  logic [SEL_W-1:0]            div_sel,
  input  logic [CNT_W-1:0]            div_data,
  output logic [NUM_CH-1:0]           tick,
  output logic [NUM_CH-1:0]           sq_clk,
  output logic [NUM_CH-1:0]           done,
  output logic [NUM_CH*ELAPSED_W-1:0] elapsed
);

  logic [NUM_CH-1:0] load;

  // Select values at or beyond NUM_CH match no channel, so such writes vanish.
  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = div_wr && (int'(div_sel) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .ELAPSED_W   (ELAPSED_W)
    ) u_ch (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (ch_en[g]),
      .clear_i     (ch_clear[g]),
      .oneshot_i   (ch_oneshot[g]),
      .load_i      (load[g]),
      .load_data_i (div_data),
      .tick_o      (tick[g]),
      .sq_clk_o    (sq_clk[g]),
      .done_o      (done[g]),
      .elapsed_o   (elapsed[g*ELAPSED_W +: ELAPSED_W])
    );
  end

endmodule

// File: tb/tb_tick_generator_multi.sv
module tb_tick_generator_multi;

  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 16;
  localparam int DEF_DIV = 7;
  localparam int EW      = 8;
  localparam int EL_MAX  = (1 << EW) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_CH-1:0]      ch_en, ch_clear, ch_oneshot;
  logic                   div_wr;
  logic [1:0]             div_sel;
  logic [CNT_W-1:0]       div_data;
  logic [NUM_CH-1:0]      tick, sq_clk, done;
  logic [NUM_CH*EW-1:0]   elapsed;

  always #5 clk = ~clk;

  tick_generator_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF_DIV),
    .ELAPSED_W   (EW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_en      (ch_en),
    .ch_clear   (ch_clear),
    .ch_oneshot (ch_oneshot),
    .div_wr     (div_wr),
    .div_sel    (div_sel),
    .div_data   (div_data),
    .tick       (tick),
    .sq_clk     (sq_clk),
    .done       (done),
    .elapsed    (elapsed)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: enabled edges since the last tick, divisor, fired flag,
  // square-wave level and tick count (unbounded int, clamped on compare).
  int m_since[NUM_CH];
  int m_div[NUM_CH];
  int m_ticks[NUM_CH];
  bit m_fired[NUM_CH];
  bit m_sq[NUM_CH];
  bit m_tick[NUM_CH];

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_edge(input logic r, input logic [NUM_CH-1:0] en,
                            input logic [NUM_CH-1:0] clr, input logic [NUM_CH-1:0] os,
                            input logic wr, input logic [1:0] sel, input logic [CNT_W-1:0] data);
    for (int c = 0; c < NUM_CH; c++) begin
      int period;
      m_tick[c] = 1'b0;
      if (r) begin
        m_since[c] = 0; m_div[c] = DEF_DIV; m_ticks[c] = 0;
        m_fired[c] = 1'b0; m_sq[c] = 1'b0;
      end else begin
        period = (m_div[c] == 0) ? 1 : m_div[c];
        if (clr[c]) begin
          m_since[c] = 0; m_ticks[c] = 0; m_fired[c] = 1'b0; m_sq[c] = 1'b0;
        end else if (!m_fired[c] && en[c]) begin
          m_since[c]++;
          if (m_since[c] >= period) begin
            m_since[c] = 0;
            m_tick[c]  = 1'b1;
            m_sq[c]    = !m_sq[c];
            m_ticks[c]++;
            if (os[c]) m_fired[c] = 1'b1;
          end
        end
        if (wr && int'(sel) == c) m_div[c] = int'(data);
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [NUM_CH-1:0]    et, es, ed;
    logic [NUM_CH*EW-1:0] ee;
    for (int c = 0; c < NUM_CH; c++) begin
      et[c] = m_tick[c];
      es[c] = m_sq[c];
      ed[c] = m_fired[c];
      ee[c*EW +: EW] = EW'(min_i(m_ticks[c], EL_MAX));
    end
    n_cmp++;
    if ({tick, sq_clk, done, elapsed} !== {et, es, ed, ee}) begin
      n_bad++;
      $display("FAIL %s @%0t: got tick=%b sq=%b done=%b el=%h, want tick=%b sq=%b done=%b el=%h",
               tag, $time, tick, sq_clk, done, elapsed, et, es, ed, ee);
    end
  endtask

  task automatic step(input string tag);
    logic r, w;
    logic [NUM_CH-1:0] e, c, o;
    logic [1:0] s;
    logic [CNT_W-1:0] d;
    r = rst; e = ch_en; c = ch_clear; o = ch_oneshot; w = div_wr; s = div_sel; d = div_data;
    @(posedge clk);
    model_edge(r, e, c, o, w, s, d);
    #1;
    check_model(tag);
  endtask

  task automatic expect_int(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Steps until tick[ch] is seen; returns the number of edges taken.
  task automatic run_until_tick(input int ch, input int budget, input string tag, output int n);
    n = 0;
    while (n < budget) begin
      step(tag);
      n++;
      if (tick[ch]) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no tick on ch%0d within %0d cycles", tag, ch, budget);
  endtask

  task automatic count_ticks(input int ch, input int cycles, input string tag, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      step(tag);
      if (tick[ch]) n++;
    end
  endtask

  task automatic write_div(input int ch, input int val, input string tag);
    div_wr = 1'b1; div_sel = 2'(ch); div_data = CNT_W'(val);
    step(tag);
    div_wr = 1'b0;
  endtask

  typedef struct {
    logic       en0;
    logic       wr;
    int         data;
    logic       exp_tick;
    logic       exp_sq;
    int         exp_el;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int n;

    // en0, wr, data, tick0, sq0, elapsed0 after the edge
    tbl[0]  = '{1'b0, 1'b1, 5, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1};
    tbl[6]  = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 1};
    tbl[7]  = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 1};
    tbl[8]  = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 1};
    tbl[9]  = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 1};
    tbl[10] = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 2};
    tbl[11] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 2};
    tbl[12] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 2};
    tbl[13] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 2};
    tbl[14] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 2};
    tbl[15] = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 3};

    rst = 1'b1; ch_en = '0; ch_clear = '0; ch_oneshot = '0;
    div_wr = 1'b0; div_sel = '0; div_data = '0;
    step("reset");
    step("reset");
    expect_int("reset_outputs", int'({tick, sq_clk, done}), 0);
    expect_int("reset_elapsed", int'(elapsed), 0);
    rst = 1'b0;

    // Basic period, table driven on channel 0.
    for (int i = 0; i < 16; i++) begin
      ch_en[0] = tbl[i].en0;
      div_wr   = tbl[i].wr;
      div_sel  = 2'd0;
      div_data = CNT_W'(tbl[i].data);
      step("table");
      expect_int($sformatf("tbl%0d_tick", i), int'(tick[0]), int'(tbl[i].exp_tick));
      expect_int($sformatf("tbl%0d_sq", i), int'(sq_clk[0]), int'(tbl[i].exp_sq));
      expect_int($sformatf("tbl%0d_el", i), int'(elapsed[EW-1:0]), tbl[i].exp_el);
    end
    div_wr = 1'b0;

    // Pause / resume.
    ch_en[0] = 1'b0; ch_clear[0] = 1'b1;
    step("pause_clr");
    ch_clear[0] = 1'b0;
    write_div(0, 10, "pause_wr");
    ch_en[0] = 1'b1;
    repeat (4) step("pause_run");
    ch_en[0] = 1'b0;
    count_ticks(0, 20, "paused", n);
    expect_int("ticks_while_paused", n, 0);
    ch_en[0] = 1'b1;
    run_until_tick(0, 40, "resume", n);
    expect_int("resume_latency", n, 6);

    // One-shot on channel 1.
    ch_oneshot[1] = 1'b1;
    write_div(1, 3, "os_wr");
    ch_en[1] = 1'b1;
    run_until_tick(1, 20, "os_first", n);
    expect_int("os_first_latency", n, 3);
    expect_int("os_done_set", int'(done[1]), 1);
    count_ticks(1, 50, "os_hold", n);
    expect_int("os_no_more_ticks", n, 0);
    expect_int("os_done_held", int'(done[1]), 1);
    ch_clear[1] = 1'b1;
    step("os_clear");
    ch_clear[1] = 1'b0;
    expect_int("os_done_cleared", int'(done[1]), 0);
    expect_int("os_sq_cleared", int'(sq_clk[1]), 0);
    run_until_tick(1, 20, "os_rearm", n);
    expect_int("os_rearm_latency", n, 3);
    ch_oneshot[1] = 1'b0; ch_en[1] = 1'b0; ch_clear[1] = 1'b1;
    step("os_exit");
    ch_clear[1] = 1'b0;

    // Divisor shrink mid-count; also a write landing on a clear cycle.
    ch_clear[0] = 1'b1; div_wr = 1'b1; div_sel = 2'd0; div_data = CNT_W'(100);
    step("shrink_clr_wr");
    ch_clear[0] = 1'b0; div_wr = 1'b0;
    count_ticks(0, 50, "shrink_run", n);
    expect_int("shrink_no_early_tick", n, 0);
    write_div(0, 20, "shrink_wr");
    expect_int("shrink_wr_edge_no_tick", int'(tick[0]), 0);
    run_until_tick(0, 5, "shrink_wrap", n);
    expect_int("shrink_wrap_latency", n, 1);
    run_until_tick(0, 40, "shrink_p1", n);
    expect_int("shrink_period_1", n, 20);
    run_until_tick(0, 40, "shrink_p2", n);
    expect_int("shrink_period_2", n, 20);
    write_div(0, 0, "div0_wr");
    count_ticks(0, 5, "div0", n);
    expect_int("div0_every_cycle", n, 5);
    write_div(0, 1, "div1_wr");
    count_ticks(0, 5, "div1", n);
    expect_int("div1_every_cycle", n, 5);

    // Clear coinciding with a terminal count.
    write_div(0, 4, "ct_wr");
    run_until_tick(0, 10, "ct_align", n);
    expect_int("ct_period", n, 4);
    repeat (3) step("ct_run");
    ch_clear[0] = 1'b1;
    step("ct_clear");
    ch_clear[0] = 1'b0;
    expect_int("ct_no_tick", int'(tick[0]), 0);
    expect_int("ct_elapsed_zero", int'(elapsed[EW-1:0]), 0);
    run_until_tick(0, 10, "ct_after", n);
    expect_int("ct_restart_latency", n, 4);

    // Out-of-range select leaves every divisor alone.
    ch_clear[0] = 1'b1; div_wr = 1'b1; div_sel = 2'd3; div_data = CNT_W'(1);
    step("sel_oor");
    ch_clear[0] = 1'b0; div_wr = 1'b0;
    run_until_tick(0, 10, "sel_oor_chk", n);
    expect_int("sel_oor_div_kept", n, 4);

    // Saturation on ch0 while ch1 counts independently.
    write_div(0, 1, "sat_wr0");
    write_div(1, 3, "sat_wr1");
    ch_en[1] = 1'b1; ch_clear[1:0] = 2'b11;
    step("sat_clr");
    ch_clear[1:0] = 2'b00;
    count_ticks(0, 300, "sat_run", n);
    expect_int("sat_ticks_keep_pulsing", n, 300);
    expect_int("sat_elapsed_ch0", int'(elapsed[EW-1:0]), EL_MAX);
    expect_int("sat_elapsed_ch1", int'(elapsed[EW +: EW]), 100);

    // Reset mid-run restores the default divisor everywhere.
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0;
    expect_int("rst_mid_outputs", int'({tick, sq_clk, done}), 0);
    expect_int("rst_mid_elapsed", int'(elapsed), 0);
    ch_en = '1;
    run_until_tick(2, 20, "rst_default", n);
    expect_int("rst_default_div", n, DEF_DIV);
    expect_int("rst_default_div_ch0", int'(tick[0]), 1);

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst        = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        ch_en[c]    = ($urandom_range(0, 3) != 0);
        ch_clear[c] = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 49) == 0) ch_oneshot[c] = ~ch_oneshot[c];
      end
      div_wr   = ($urandom_range(0, 9) == 0);
      div_sel  = 2'($urandom_range(0, 3));
      div_data = CNT_W'($urandom_range(0, 9));
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
